mul_accum_ser: RTL and testbench



---
 rtl/mul_pkg.sv | 33 +++
 rtl/sat_add16.sv | 28 ++
 rtl/mul_accum_ser.sv | 159 +++++++++++++++
 tb/tb_mul_accum_ser.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the serial multiply-accumulate datapath:
//   - state_e  : output-serialiser FSM states (accumulate, low byte, high byte)
//   - PROD_W   : width of one product from the 4x4 multiplier
//   - ACC_W    : accumulator width
//   - ACC_MAX  : value the accumulator clamps to on overflow
//   - sat_clip : folds a one-bit-wider sum back into ACC_W bits, clamping
// ---------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_OUT_LO = 2'd1,
        ST_OUT_HI = 2'd2
    } state_e;

    localparam int             PROD_W  = 8;
    localparam int             ACC_W   = 16;
    localparam logic [ACC_W-1:0] ACC_MAX = 16'hFFFF;

    // Clamp a carry-extended sum to the accumulator range.
    function automatic logic [ACC_W-1:0] sat_clip(input logic [ACC_W:0] full);
        logic [ACC_W-1:0] res;
        if (full[ACC_W]) begin
            res = ACC_MAX;
        end else begin
            res = full[ACC_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_add16.sv
// ---------------------------------------------------------------------------
// sat_add16
// Combinational 16-bit + 8-bit unsigned adder that clamps at 0xFFFF.
// Ports:
//   i_acc  [15:0] in   current accumulator value
//   i_add  [7:0]  in   product to add
//   o_sum  [15:0] out  clamped sum
//   o_ovf         out  1 when the true sum exceeded 0xFFFF
// ---------------------------------------------------------------------------
module sat_add16
    import mul_pkg::*;
(
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_add,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W:0] w_full;

    // Widen by one bit so the carry out is the overflow flag.
    always_comb begin
        w_full = {1'b0, i_acc} + {{(ACC_W-PROD_W+1){1'b0}}, i_add};
        o_ovf  = w_full[ACC_W];
        o_sum  = sat_clip(w_full);
    end

endmodule

// File: rtl/mul_accum_ser.sv
// ---------------------------------------------------------------------------
// mul_accum_ser
// Sums N_TERMS 8-bit products into a saturating 16-bit accumulator and
// streams the result out as two bytes, low byte first.
// Ports:
//   clk         in        rising-edge clock
//   rst_n       in        asynchronous active-low reset
//   clear       in        synchronous abort of partial or pending result
//   in_valid    in        product_in is valid
//   in_ready    out       a product can be accepted this cycle
//   product_in  in  [7:0] unsigned product
//   out_valid   out       out_data is valid
//   out_ready   in        sink takes out_data this cycle
//   out_data    out [7:0] result byte
//   out_last    out       high (final) byte of the result
//   sat         out       current or last result saturated
// All outputs decode registered state only; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module mul_accum_ser
    import mul_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              sat
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_e             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;

    state_e             w_state_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_sat_nxt;

    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;

    sat_add16 u_sat_add16 (
        .i_acc (r_acc),
        .i_add (product_in),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // Next-state logic; clear wins over everything, including a product
    // presented in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_sat_nxt   = r_sat;
        if (clear) begin
            w_state_nxt = ST_ACC;
            w_acc_nxt   = {ACC_W{1'b0}};
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_sat_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (in_valid) begin
                        w_acc_nxt = w_sum;
                        // Saturation is sticky until the result drains.
                        w_sat_nxt = r_sat | w_ovf;
                        if (r_cnt == LAST_CNT) begin
                            w_cnt_nxt   = {CNT_W{1'b0}};
                            w_state_nxt = ST_OUT_LO;
                        end else begin
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_acc_nxt = r_acc;
                        w_cnt_nxt = r_cnt;
                    end
                end
                ST_OUT_LO: begin
                    if (out_ready) begin
                        w_state_nxt = ST_OUT_HI;
                    end else begin
                        w_state_nxt = ST_OUT_LO;
                    end
                end
                ST_OUT_HI: begin
                    if (out_ready) begin
                        w_state_nxt = ST_ACC;
                        w_acc_nxt   = {ACC_W{1'b0}};
                        w_sat_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_OUT_HI;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACC;
                    w_acc_nxt   = {ACC_W{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_sat_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State, accumulator, term counter and saturation flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    // Output decode from registered state; the byte mux keeps data stable
    // under backpressure because r_acc does not change outside ST_ACC.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        sat       = r_sat;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
            end
            ST_OUT_LO: begin
                out_valid = 1'b1;
                out_data  = r_acc[7:0];
            end
            ST_OUT_HI: begin
                out_valid = 1'b1;
                out_data  = r_acc[15:8];
                out_last  = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_accum_ser.sv
// ---------------------------------------------------------------------------
// tb_mul_accum_ser
// Three instances share clock and reset: index 0 sums 4 terms, index 1 sums
// 300 terms, index 2 sums a single term. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_mul_accum_ser;

    logic            clk;
    logic            rst_n;
    logic [2:0]      clear;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready;
    logic [2:0][7:0] product_in;
    logic [2:0]      out_valid;
    logic [2:0]      out_ready;
    logic [2:0][7:0] out_data;
    logic [2:0]      out_last;
    logic [2:0]      sat;

    int ntests = 0;
    int nfail  = 0;

    mul_accum_ser #(.N_TERMS(4), .CNT_W(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .product_in(product_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .sat(sat[0])
    );

    mul_accum_ser #(.N_TERMS(300), .CNT_W(10)) u_dut300 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .product_in(product_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .sat(sat[1])
    );

    mul_accum_ser #(.N_TERMS(1), .CNT_W(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .product_in(product_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .sat(sat[2])
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present one product and hold it until accepted; then idle for gap cycles.
    task automatic send(input int d, input logic [7:0] p, input int gap, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (in_ready[d] !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) begin
            ok = 1'b0;
        end else begin
            in_valid[d]   = 1'b1;
            product_in[d] = p;
            cyc();
            in_valid[d]   = 1'b0;
            repeat (gap) cyc();
        end
    endtask

    // Collect one two-byte result, optionally stalling before each byte.
    task automatic recv(input int d, input int max_stall,
                        output logic [7:0] lo, output logic [7:0] hi,
                        output logic llo, output logic lhi, output logic slo,
                        output logic ok);
        int n;
        int st;
        n  = 0;
        ok = 1'b1;
        lo = 8'h00; hi = 8'h00; llo = 1'b0; lhi = 1'b0; slo = 1'b0;
        out_ready[d] = 1'b0;
        while (out_valid[d] !== 1'b1 && n < 2000) begin
            cyc();
            n++;
        end
        if (n >= 2000) begin
            ok = 1'b0;
        end else begin
            st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            repeat (st) cyc();
            lo  = out_data[d];
            llo = out_last[d];
            slo = sat[d];
            out_ready[d] = 1'b1;
            cyc();
            st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
            if (st > 0) begin
                out_ready[d] = 1'b0;
                repeat (st) cyc();
            end
            hi  = out_data[d];
            lhi = out_last[d];
            out_ready[d] = 1'b1;
            cyc();
            out_ready[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            ntests++; if (in_ready[d] !== 1'b1) begin nfail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, in_ready[d]); end
            ntests++; if (out_valid[d] !== 1'b0) begin nfail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, out_valid[d]); end
            ntests++; if (out_data[d] !== 8'h00) begin nfail++; $display("FAIL reset_out_data[%0d]: got %h expected 00", d, out_data[d]); end
            ntests++; if (out_last[d] !== 1'b0) begin nfail++; $display("FAIL reset_out_last[%0d]: got %b expected 0", d, out_last[d]); end
            ntests++; if (sat[d] !== 1'b0) begin nfail++; $display("FAIL reset_sat[%0d]: got %b expected 0", d, sat[d]); end
        end
    endtask

    task automatic test_basic();
        logic [7:0] prods [4];
        logic [7:0] lo, hi;
        logic llo, lhi, slo, ok, ok_all;
        prods  = '{8'd225, 8'd100, 8'd1, 8'd0};
        ok_all = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(0, prods[i], 0, ok);
            ok_all &= ok;
        end
        ntests++; if (ok_all !== 1'b1) begin nfail++; $display("FAIL basic_send: got timeout expected accept"); end
        ntests++; if (out_valid[0] !== 1'b1) begin nfail++; $display("FAIL basic_latency: out_valid got %b expected 1", out_valid[0]); end
        recv(0, 0, lo, hi, llo, lhi, slo, ok);
        ntests++; if (ok !== 1'b1) begin nfail++; $display("FAIL basic_recv: got timeout expected result"); end
        ntests++; if (lo !== 8'h46) begin nfail++; $display("FAIL basic_lo: got %h expected 46", lo); end
        ntests++; if (llo !== 1'b0) begin nfail++; $display("FAIL basic_lo_last: got %b expected 0", llo); end
        ntests++; if (slo !== 1'b0) begin nfail++; $display("FAIL basic_sat: got %b expected 0", slo); end
        ntests++; if (hi !== 8'h01) begin nfail++; $display("FAIL basic_hi: got %h expected 01", hi); end
        ntests++; if (lhi !== 1'b1) begin nfail++; $display("FAIL basic_hi_last: got %b expected 1", lhi); end
        ntests++; if (in_ready[0] !== 1'b1) begin nfail++; $display("FAIL basic_ready_back: got %b expected 1", in_ready[0]); end
    endtask

    task automatic test_backpressure();
        logic [7:0] prods [4];
        logic [7:0] lo, hi;
        logic llo, lhi, slo, ok;
        prods = '{8'd225, 8'd100, 8'd1, 8'd0};
        for (int i = 0; i < 4; i++) send(0, prods[i], (i < 3) ? 1 : 0, ok);
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ntests++; if (out_data[0] !== 8'h46) begin nfail++; $display("FAIL bp_hold_data: got %h expected 46", out_data[0]); end
            ntests++; if (in_ready[0] !== 1'b0) begin nfail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready[0]); end
            in_valid[0] = 1'b1;           // ignored while outputting
            product_in[0] = 8'hAA;
            cyc();
            in_valid[0] = 1'b0;
        end
        recv(0, 0, lo, hi, llo, lhi, slo, ok);
        ntests++; if (lo !== 8'h46) begin nfail++; $display("FAIL bp_lo: got %h expected 46", lo); end
        ntests++; if (hi !== 8'h01) begin nfail++; $display("FAIL bp_hi: got %h expected 01", hi); end
        ntests++; if (in_ready[0] !== 1'b1) begin nfail++; $display("FAIL bp_ready_back: got %b expected 1", in_ready[0]); end
    endtask

    task automatic test_saturation();
        logic [7:0] lo, hi;
        logic llo, lhi, slo, ok;
        for (int i = 0; i < 300; i++) send(1, 8'd225, 0, ok);
        recv(1, 0, lo, hi, llo, lhi, slo, ok);
        ntests++; if ({hi, lo} !== 16'hFFFF) begin nfail++; $display("FAIL sat_value: got %h expected ffff", {hi, lo}); end
        ntests++; if (slo !== 1'b1) begin nfail++; $display("FAIL sat_flag: got %b expected 1", slo); end
        ntests++; if (sat[1] !== 1'b0) begin nfail++; $display("FAIL sat_drained: got %b expected 0", sat[1]); end
        for (int i = 0; i < 300; i++) send(1, 8'd1, 0, ok);
        recv(1, 0, lo, hi, llo, lhi, slo, ok);
        ntests++; if ({hi, lo} !== 16'h012C) begin nfail++; $display("FAIL sat_next_value: got %h expected 012c", {hi, lo}); end
        ntests++; if (slo !== 1'b0) begin nfail++; $display("FAIL sat_next_flag: got %b expected 0", slo); end
    endtask

    task automatic test_clear();
        logic [7:0] lo, hi;
        logic llo, lhi, slo, ok;
        send(0, 8'd50, 0, ok);
        send(0, 8'd60, 0, ok);
        clear[0] = 1'b1;
        in_valid[0] = 1'b1;
        product_in[0] = 8'd70;
        cyc();
        clear[0] = 1'b0;
        in_valid[0] = 1'b0;
        for (int i = 1; i <= 4; i++) send(0, 8'(i), 0, ok);
        recv(0, 0, lo, hi, llo, lhi, slo, ok);
        ntests++; if ({hi, lo} !== 16'h000A) begin nfail++; $display("FAIL clear_acc: got %h expected 000a", {hi, lo}); end
        // Abort a pending result from the low-byte state.
        for (int i = 0; i < 4; i++) send(0, 8'd5, 0, ok);
        clear[0] = 1'b1;
        cyc();
        clear[0] = 1'b0;
        ntests++; if (out_valid[0] !== 1'b0) begin nfail++; $display("FAIL clear_out_valid: got %b expected 0", out_valid[0]); end
        ntests++; if (in_ready[0] !== 1'b1) begin nfail++; $display("FAIL clear_in_ready: got %b expected 1", in_ready[0]); end
    endtask

    task automatic test_async_reset();
        logic [7:0] lo, hi;
        logic llo, lhi, slo, ok;
        for (int i = 0; i < 4; i++) send(0, 8'd3, 0, ok);
        out_ready[0] = 1'b1;
        cyc();
        out_ready[0] = 1'b0;
        ntests++; if (out_last[0] !== 1'b1) begin nfail++; $display("FAIL areset_in_hi: got %b expected 1", out_last[0]); end
        #3;
        rst_n = 1'b0;
        #1;
        ntests++; if (out_valid[0] !== 1'b0) begin nfail++; $display("FAIL areset_out_valid: got %b expected 0", out_valid[0]); end
        ntests++; if (in_ready[0] !== 1'b1) begin nfail++; $display("FAIL areset_in_ready: got %b expected 1", in_ready[0]); end
        ntests++; if (sat[0] !== 1'b0) begin nfail++; $display("FAIL areset_sat: got %b expected 0", sat[0]); end
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 8'd10, 0, ok);
        recv(0, 0, lo, hi, llo, lhi, slo, ok);
        ntests++; if ({hi, lo} !== 16'h0028) begin nfail++; $display("FAIL areset_after: got %h expected 0028", {hi, lo}); end
    endtask

    task automatic test_n1();
        logic [7:0] vals [2];
        logic [7:0] lo, hi;
        int busy;
        logic ok;
        vals = '{8'd7, 8'd9};
        for (int j = 0; j < 2; j++) begin
            lo = 8'h00; hi = 8'hEE; busy = 0;
            send(2, vals[j], 0, ok);
            out_ready[2] = 1'b1;
            for (int k = 0; k < 6; k++) begin
                if (in_ready[2] === 1'b0) busy++;
                if (out_valid[2] === 1'b1 && out_last[2] === 1'b0) lo = out_data[2];
                if (out_valid[2] === 1'b1 && out_last[2] === 1'b1) hi = out_data[2];
                cyc();
            end
            out_ready[2] = 1'b0;
            ntests++; if (lo !== vals[j]) begin nfail++; $display("FAIL n1_lo: got %h expected %h", lo, vals[j]); end
            ntests++; if (hi !== 8'h00) begin nfail++; $display("FAIL n1_hi: got %h expected 00", hi); end
            ntests++; if (busy != 2) begin nfail++; $display("FAIL n1_busy: got %0d expected 2", busy); end
        end
    endtask

    // Random products, gaps and stalls against a plain-arithmetic model:
    // the result is min(true sum, 65535), saturated iff the true sum exceeds it.
    task automatic test_random(input int d, input int nterms, input int nres,
                               input int pmin, input int maxgap, input int maxstall);
        logic [7:0] lo, hi, p;
        logic llo, lhi, slo, ok;
        int unsigned total;
        int unsigned expv;
        for (int r = 0; r < nres; r++) begin
            total = 0;
            for (int i = 0; i < nterms; i++) begin
                p = 8'($urandom_range(255, pmin));
                total += p;
                send(d, p, int'($urandom_range(maxgap, 0)), ok);
            end
            expv = (total > 65535) ? 65535 : total;
            recv(d, maxstall, lo, hi, llo, lhi, slo, ok);
            ntests++; if ({hi, lo} !== 16'(expv)) begin nfail++; $display("FAIL rand_value[%0d]: got %h expected %h", d, {hi, lo}, 16'(expv)); end
            ntests++; if (slo !== (total > 65535)) begin nfail++; $display("FAIL rand_sat[%0d]: got %b expected %b", d, slo, (total > 65535)); end
            ntests++; if ({llo, lhi} !== 2'b01) begin nfail++; $display("FAIL rand_last[%0d]: got %b expected 01", d, {llo, lhi}); end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 3'b000;
        in_valid   = 3'b000;
        out_ready  = 3'b000;
        product_in = '0;
        cyc();
        test_reset();
        cyc();
        rst_n = 1'b1;
        cyc();
        test_basic();
        test_backpressure();
        test_saturation();
        test_clear();
        test_async_reset();
        test_n1();
        test_random(0, 4, 10, 0, 2, 3);
        test_random(1, 300, 3, 170, 0, 2);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
